pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter RETIRE_W, default 16, width of retired-instruction counter.
REQ-002 Parameter DRAIN_MAX, default 3, drain-timeout bound in cycles (number of in-flight stages).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 hazard  input  1  DOF-stage data hazard; 1 = stall fetch and decode.
REQ-006 branch_taken  input  1  EX-stage branch/jump resolved taken this cycle.
REQ-007 halt_req  input  1  level; 1 = request halt, 0 = run.
REQ-008 step  input  1  single-cycle pulse; issue one instruction while halted.
REQ-009 pc_en  output  1  PC register load enable.
REQ-010 if_en  output  1  instruction_reg/pc_1 load enable.
REQ-011 bubble  output  1  zero RW/MW/BS/DA entering EX register.
REQ-012 wb_en  output  1  register-file write qualify (valid instruction in WB).
REQ-013 halted  output  1  1 while in HALT state.
REQ-014 state  output  3  current FSM state encoding.
REQ-015 retired  output  RETIRE_W  count of instructions reaching WB.

Function
REQ-016 FSM states: RUN, DRAIN, HALT, STEP; encodings RUN=0, DRAIN=1, HALT=2, STEP=3.
REQ-017 Per-stage valid bits v_if, v_dof, v_ex shall track live instructions; wb_en = v_ex (registered, zero combinational path from inputs).
REQ-018 RUN, no hazard, no branch: pc_en=1, if_en=1, bubble=0; v_if<=1, v_dof<=v_if, v_ex<=v_dof.
REQ-019 RUN with hazard=1 and branch_taken=0: pc_en=0, if_en=0, bubble=1 in same cycle; v_if holds, v_dof<=0, v_ex<=v_dof; stall lasts exactly as many cycles as hazard is high.
REQ-020 branch_taken=1: pc_en=1, if_en=1, bubble=1; v_dof<=0 and v_if<=1 (branch target fetched); hazard ignored that cycle.
REQ-021 RUN with halt_req=1 -> DRAIN next cycle; the instruction fetched in the transition cycle is allowed to complete.
REQ-022 DRAIN: pc_en=0, if_en=0, bubble=1 for any new entry; v_if<=0; -> HALT when v_if, v_dof, v_ex are all 0, in at most DRAIN_MAX cycles.
REQ-023 branch_taken during DRAIN shall still load PC (pc_en=1) so the resume address is correct; v_if stays 0.
REQ-024 HALT: pc_en=0, if_en=0, bubble=1, halted=1; halt_req=0 -> RUN; step=1 with halt_req=1 -> STEP; halt_req=0 has priority over step.
REQ-025 STEP: exactly one cycle with pc_en=1, if_en=1, v_if<=1; -> DRAIN unconditionally.
REQ-026 retired increments by 1 on each cycle with wb_en=1; wraps from 2^RETIRE_W-1 to 0.
REQ-027 hazard and step are don't-care in HALT; hazard is don't-care in DRAIN.

Reset
REQ-028 rst=0 shall immediately force state=RUN, v_if=v_dof=v_ex=0, retired=0, halted=0, wb_en=0, independent of clk.
REQ-029 After rst release, first rising edge shall fetch (pc_en=1 if hazard=0); wb_en first rises on the 3rd edge.
REQ-030 Reset mid-DRAIN or mid-STEP shall discard all in-flight valids with no spurious wb_en pulse.

Structure
REQ-031 State encodings and RETIRE_W default shall live in the shared CPU constants package alongside the opcode constants.
REQ-032 Valid-bit shift chain shall be one sub-module, pipe_valid, with inputs advance, squash_dof, fetch_valid.
REQ-033 No latches; outputs pc_en/if_en/bubble are combinational from state and inputs; all others registered.

Verification
REQ-034 Reset release, hazard=0 for 10 cycles -> wb_en rises on edge 3; retired=8 after edge 10.
REQ-035 hazard=1 for 2 cycles in RUN -> pc_en=0, bubble=1 both cycles; exactly 2 wb_en-low cycles appear 2 cycles later.
REQ-036 hazard=1 and branch_taken=1 same cycle -> pc_en=1, bubble=1, v_dof cleared; retired skips exactly 1 instruction.
REQ-037 halt_req=1 in RUN -> DRAIN, halted=1 within 4 cycles; step pulse -> exactly one wb_en pulse, retired +1, back to HALT.
REQ-038 RETIRE_W=4, 17 retired instructions -> retired=1; rst=0 asserted mid-DRAIN -> state=RUN, retired=0 immediately.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU constants: opcode values, pipeline-control state encodings
// and the default width of the retired-instruction counter.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_NOP  = 7'h00;
    localparam logic [6:0] OP_ADD  = 7'h02;
    localparam logic [6:0] OP_SUB  = 7'h05;
    localparam logic [6:0] OP_LD   = 7'h21;
    localparam logic [6:0] OP_ST   = 7'h01;
    localparam logic [6:0] OP_BZ   = 7'h60;
    localparam logic [6:0] OP_JMP  = 7'h44;

    localparam int RETIRE_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_DRAIN = 3'd1,
        ST_HALT  = 3'd2,
        ST_STEP  = 3'd3
    } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control/status bundle between the pipeline controller and the datapath.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int RETIRE_W = RETIRE_W_DEF
);
    logic                hazard;
    logic                branch_taken;
    logic                halt_req;
    logic                step;
    logic                pc_en;
    logic                if_en;
    logic                bubble;
    logic                wb_en;
    logic                halted;
    logic [2:0]          state;
    logic [RETIRE_W-1:0] retired;

    modport master (
        output hazard, branch_taken, halt_req, step,
        input  pc_en, if_en, bubble, wb_en, halted, state, retired
    );

    modport slave (
        input  hazard, branch_taken, halt_req, step,
        output pc_en, if_en, bubble, wb_en, halted, state, retired
    );
endinterface

// File: rtl/pipe_ctrl_valid.sv
// Per-stage valid bits (IF -> DOF -> EX). EX always accepts what DOF holds;
// a non-advancing cycle freezes IF and pushes a bubble into DOF.
module pipe_valid (
    input  logic clk,
    input  logic rst,
    input  logic advance,
    input  logic squash_dof,
    input  logic fetch_valid,
    output logic v_if,
    output logic v_dof,
    output logic v_ex
);

    // Shift the valid chain; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_if  <= 1'b0;
            v_dof <= 1'b0;
            v_ex  <= 1'b0;
        end else begin
            if (advance) begin
                v_if <= fetch_valid;
            end
            v_dof <= advance & ~squash_dof & v_if;
            v_ex  <= v_dof;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall/flush/halt/single-step sequencing plus a
// retired-instruction counter.
//
//   state | meaning
//   RUN   | normal issue; hazard stalls IF/DOF, branch flushes DOF
//   DRAIN | no new fetch; let in-flight instructions reach WB
//   HALT  | pipeline empty, waiting for resume or a step pulse
//   STEP  | issue exactly one instruction, then drain again
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RETIRE_W  = RETIRE_W_DEF,
    parameter int DRAIN_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    localparam int DCW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

    pipe_state_e         state_q, state_d;
    logic                halted_q;
    logic [RETIRE_W-1:0] retired_q;
    logic [DCW-1:0]      drain_cnt;
    logic                drain_tc;
    logic                drained;
    logic                advance, squash_dof, fetch_valid;
    logic                pc_en, if_en, bubble;
    logic                v_if, v_dof, v_ex;

    pipe_valid u_valid (
        .clk         (clk),
        .rst         (rst),
        .advance     (advance),
        .squash_dof  (squash_dof),
        .fetch_valid (fetch_valid),
        .v_if        (v_if),
        .v_dof       (v_dof),
        .v_ex        (v_ex)
    );

    // EX empties on the same edge that IF and DOF are seen empty, so this is
    // the last DRAIN cycle.
    assign drained  = ~v_if & ~v_dof;
    assign drain_tc = (drain_cnt == '0);

    // Next-state and combinational enables from state and inputs.
    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b0;
        if_en       = 1'b0;
        bubble      = 1'b1;
        advance     = 1'b1;
        fetch_valid = 1'b0;
        squash_dof  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (bus.branch_taken) begin
                    pc_en       = 1'b1;
                    if_en       = 1'b1;
                    fetch_valid = 1'b1;
                    squash_dof  = 1'b1;
                end else if (bus.hazard) begin
                    advance = 1'b0;
                end else begin
                    pc_en       = 1'b1;
                    if_en       = 1'b1;
                    bubble      = 1'b0;
                    fetch_valid = 1'b1;
                end
                if (bus.halt_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // PC still follows a late branch so resume starts at the target.
                pc_en      = bus.branch_taken;
                squash_dof = bus.branch_taken;
                if (drained || drain_tc) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!bus.halt_req) begin
                    state_d = ST_RUN;
                end else if (bus.step) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                pc_en       = 1'b1;
                if_en       = 1'b1;
                bubble      = 1'b0;
                fetch_valid = 1'b1;
                state_d     = ST_DRAIN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == ST_HALT);
        end
    end

    // Drain timeout: loaded on DRAIN entry, terminal count bounds the stay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt <= '0;
        end else if (state_q != ST_DRAIN && state_d == ST_DRAIN) begin
            drain_cnt <= DCW'(DRAIN_MAX - 1);
        end else if (state_q == ST_DRAIN && !drain_tc) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Count an instruction on the edge it enters WB, so the count already
    // includes the instruction currently asserting wb_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
        end else if (v_dof) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign bus.pc_en   = pc_en;
    assign bus.if_en   = if_en;
    assign bus.bubble  = bubble;
    assign bus.wb_en   = v_ex;
    assign bus.halted  = halted_q;
    assign bus.state   = state_q;
    assign bus.retired = retired_q;

endmodule
